// File: rtl/tb_virt_periph_pkg.sv
// rtl/tb_virt_periph_pkg.sv - address map, pass magic and register-select decode for the virtual peripheral
package tb_virt_periph_pkg;

  localparam logic [31:0] ADDR_PRINT       = 32'h1000_0000;
  localparam logic [31:0] ADDR_TEST_STATUS = 32'h2000_0000;
  localparam logic [31:0] ADDR_EXIT        = 32'h2000_0004;
  localparam logic [31:0] ADDR_TIMER_VAL   = 32'h1500_0000;
  localparam logic [31:0] ADDR_TIMER_CTRL  = 32'h1500_0004;
  localparam logic [31:0] PASS_MAGIC       = 32'd123456789;

  typedef enum logic [2:0] {
    SEL_PRINT,
    SEL_STATUS,
    SEL_EXIT,
    SEL_TMR_VAL,
    SEL_TMR_CTRL,
    SEL_NONE
  } reg_sel_e;

  // Low two address bits are don't-care: registers are word aligned.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    logic [31:0] word;
    word = addr & ~32'h3;
    if (word == ADDR_PRINT)            return SEL_PRINT;
    else if (word == ADDR_TEST_STATUS) return SEL_STATUS;
    else if (word == ADDR_EXIT)        return SEL_EXIT;
    else if (word == ADDR_TIMER_VAL)   return SEL_TMR_VAL;
    else if (word == ADDR_TIMER_CTRL)  return SEL_TMR_CTRL;
    else                               return SEL_NONE;
  endfunction

endpackage

// File: rtl/tb_virt_periph_fifo.sv
// rtl/tb_virt_periph_fifo.sv - synchronous stdout character FIFO, power-of-two depth
module tb_virt_periph_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/tb_virt_periph_responder.sv
// rtl/tb_virt_periph_responder.sv - OBI-side virtual peripheral: stdout, test status, exit code, countdown timer
module tb_virt_periph_responder
  import tb_virt_periph_pkg::*;
#(
  parameter int PRINT_FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        print_valid_o,
  output logic [7:0]  print_char_o,
  input  logic        print_ready_i,
  output logic        timer_irq_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  reg_sel_e    w_sel;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_accept;
  logic        w_wr_full;
  logic        w_push;
  logic        w_pop;
  logic        w_locked;
  logic [31:0] w_rdata;

  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_passed;
  logic        r_failed;
  logic        r_exit_valid;
  logic [31:0] r_exit_value;
  logic [31:0] r_count;
  logic        r_en;
  logic        r_irq;

  assign w_sel = decode_addr(addr_i);

  // Any PRINT write stalls while the FIFO is full so no character is lost.
  assign gnt_o     = req_i && !(we_i && (w_sel == SEL_PRINT) && w_fifo_full);
  assign w_accept  = req_i && gnt_o;
  assign w_wr_full = w_accept && we_i && (be_i == 4'hF);
  assign w_push    = w_accept && we_i && (w_sel == SEL_PRINT) && be_i[0];
  assign w_pop     = !w_fifo_empty && print_ready_i;
  assign w_locked  = r_passed || r_failed || r_exit_valid;

  always_comb begin
    w_rdata = '0;
    if (w_accept && !we_i) begin
      case (w_sel)
        SEL_TMR_VAL:  w_rdata = r_count;
        SEL_TMR_CTRL: w_rdata = {31'b0, r_en};
        default:      w_rdata = '0;
      endcase
    end
  end

  tb_virt_periph_fifo #(
    .DEPTH (PRINT_FIFO_DEPTH),
    .WIDTH (8)
  ) u_print_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (wdata_i[7:0]),
    .pop_i   (w_pop),
    .data_o  (print_char_o),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_passed     <= 1'b0;
      r_failed     <= 1'b0;
      r_exit_valid <= 1'b0;
      r_exit_value <= '0;
      r_count      <= '0;
      r_en         <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_rvalid <= w_accept;
      r_rdata  <= w_rdata;
      // First terminal event wins; later status/exit writes are acknowledged only.
      if (w_wr_full && !w_locked) begin
        if (w_sel == SEL_STATUS) begin
          if (wdata_i == PASS_MAGIC) r_passed <= 1'b1;
          else                       r_failed <= 1'b1;
        end
        if (w_sel == SEL_EXIT) begin
          r_exit_valid <= 1'b1;
          r_exit_value <= wdata_i;
        end
      end
      if (w_wr_full && (w_sel == SEL_TMR_VAL)) begin
        r_count <= wdata_i;
        r_irq   <= 1'b0;
      end else if (r_en && (r_count != '0)) begin
        r_count <= r_count - 32'd1;
        if (r_count == 32'd1) r_irq <= 1'b1;
      end
      if (w_wr_full && (w_sel == SEL_TMR_CTRL)) r_en <= wdata_i[0];
    end
  end

  assign rvalid_o       = r_rvalid;
  assign rdata_o        = r_rdata;
  assign print_valid_o  = !w_fifo_empty;
  assign timer_irq_o    = r_irq;
  assign tests_passed_o = r_passed;
  assign tests_failed_o = r_failed;
  assign exit_valid_o   = r_exit_valid;
  assign exit_value_o   = r_exit_value;

endmodule

// File: tb/tb_tb_virt_periph_responder.sv
// tb/tb_tb_virt_periph_responder.sv - directed and random bench with a queue-based reference model
module tb_tb_virt_periph_responder;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] A_PRINT  = 32'h1000_0000;
  localparam logic [31:0] A_STATUS = 32'h2000_0000;
  localparam logic [31:0] A_EXIT   = 32'h2000_0004;
  localparam logic [31:0] A_TVAL   = 32'h1500_0000;
  localparam logic [31:0] A_TCTRL  = 32'h1500_0004;
  localparam logic [31:0] MAGIC    = 32'd123456789;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        pvalid;
  logic [7:0]  pchar;
  logic        pready = 1'b0;
  logic        irq;
  logic        passed;
  logic        failed;
  logic        exv;
  logic [31:0] exval;

  always #5 clk = ~clk;

  tb_virt_periph_responder #(.PRINT_FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .gnt_o          (gnt),
    .addr_i         (addr),
    .we_i           (we),
    .be_i           (be),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .print_valid_o  (pvalid),
    .print_char_o   (pchar),
    .print_ready_i  (pready),
    .timer_irq_o    (irq),
    .tests_passed_o (passed),
    .tests_failed_o (failed),
    .exit_valid_o   (exv),
    .exit_value_o   (exval)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only, FIFO as a queue.
  logic [7:0]  m_q[$];
  logic [31:0] m_cnt = '0;
  bit          m_en, m_irq, m_pass, m_fail, m_exv, m_rv;
  logic [31:0] m_exval = '0;
  logic [31:0] m_rd = '0;

  bit          last_gnt;
  bit          last_irq;
  logic [7:0]  seen[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit model_gnt();
    return req && !(we && word_of(addr) == A_PRINT && m_q.size() == DEPTH);
  endfunction

  task automatic model_update();
    logic [31:0] w;
    logic [31:0] rd;
    bit acc, wr_all, done;
    w      = word_of(addr);
    acc    = model_gnt();
    wr_all = acc && we && (be == 4'hF);
    done   = m_pass || m_fail || m_exv;
    rd     = '0;
    if (rst) begin
      m_q.delete();
      m_cnt = '0; m_en = 0; m_irq = 0; m_pass = 0; m_fail = 0;
      m_exv = 0; m_exval = '0; m_rv = 0; m_rd = '0;
    end else begin
      if (acc && !we) rd = (w == A_TVAL) ? m_cnt : (w == A_TCTRL) ? {31'b0, m_en} : 32'd0;
      if (m_q.size() > 0 && pready) void'(m_q.pop_front());
      if (acc && we && w == A_PRINT && be[0]) m_q.push_back(wdata[7:0]);
      if (wr_all && !done && w == A_STATUS) begin
        if (wdata == MAGIC) m_pass = 1; else m_fail = 1;
      end
      if (wr_all && !done && w == A_EXIT) begin
        m_exv = 1; m_exval = wdata;
      end
      if (wr_all && w == A_TVAL) begin
        m_cnt = wdata; m_irq = 0;
      end else if (m_en && m_cnt != 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_irq = 1;
      end
      if (wr_all && w == A_TCTRL) m_en = wdata[0];
      m_rv = acc;
      m_rd = rd;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_eq("gnt", gnt, model_gnt());
    check_eq("rvalid", rvalid, m_rv);
    if (m_rv) check_eq("rdata", rdata, m_rd);
    check_eq("print_valid", pvalid, m_q.size() > 0);
    if (m_q.size() > 0) check_eq("print_char", pchar, m_q[0]);
    check_eq("irq", irq, m_irq);
    check_eq("passed", passed, m_pass);
    check_eq("failed", failed, m_fail);
    check_eq("exit_valid", exv, m_exv);
    check_eq("exit_value", exval, m_exval);
    if (pvalid && pready) seen.push_back(pchar);
    last_gnt = gnt;
    last_irq = irq;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input bit w, input logic [3:0] b, input logic [31:0] d);
    req = 1; addr = a; we = w; be = b; wdata = d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_gnt) break;
    end
    check_eq("bus_grant", last_gnt, 1);
    req = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    int found;
    logic [31:0] a;
    @(posedge clk); #1;
    step();
    rst = 0;
    check_eq("reset_rvalid", rvalid, 0);
    check_eq("reset_pvalid", pvalid, 0);
    check_eq("reset_exval", exval, 0);

    // Hello characters in order
    pready = 1; seen.delete();
    bus(A_PRINT, 1, 4'h1, 32'h48);
    bus(A_PRINT, 1, 4'hF, 32'h69);
    bus(A_PRINT, 1, 4'hF, 32'h0A);
    for (int i = 0; i < 4; i++) step();
    check_eq("hi_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check_eq("hi_0", seen[0], 8'h48);
      check_eq("hi_1", seen[1], 8'h69);
      check_eq("hi_2", seen[2], 8'h0A);
    end

    // Full FIFO stalls the ninth write until one slot drains
    pready = 0;
    for (int i = 0; i < DEPTH; i++) bus(A_PRINT, 1, 4'hF, 32'h30 + i);
    req = 1; addr = A_PRINT; we = 1; be = 4'hF; wdata = 32'h39;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("full_stall", last_gnt, 0);
    end
    pready = 1; step(); pready = 0;
    step();
    check_eq("stall_release", last_gnt, 1);
    req = 0;
    pready = 1;
    for (int i = 0; i < 12; i++) step();

    // Pass then a later failing write has no effect
    bus(A_STATUS, 1, 4'hF, MAGIC); step();
    check_eq("passed_set", passed, 1);
    bus(A_STATUS, 1, 4'hF, 32'd1); step();
    check_eq("failed_locked", failed, 0);

    do_reset();
    bus(A_EXIT, 1, 4'hF, 32'h2A); step();
    check_eq("exit_valid_set", exv, 1);
    check_eq("exit_value_set", exval, 32'h2A);
    bus(A_EXIT, 1, 4'hF, 32'h0); step();
    check_eq("exit_value_locked", exval, 32'h2A);

    // Countdown from 5 expires six cycles after the enabling write
    bus(A_TVAL, 1, 4'hF, 32'd5);
    bus(A_TCTRL, 1, 4'hF, 32'd1);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (last_irq) begin found = k; break; end
    end
    check_eq("irq_latency", found, 6);
    bus(A_TVAL, 0, 4'hF, 32'h0);
    check_eq("tval_read_rvalid", rvalid, 1);
    check_eq("tval_read_zero", rdata, 0);
    bus(A_TVAL, 1, 4'hF, 32'd3);
    check_eq("irq_cleared", irq, 0);

    // Unmapped read, then reset while a response and FIFO data are pending
    bus(32'h3000_0000, 0, 4'hF, 32'h0);
    check_eq("unmapped_rvalid", rvalid, 1);
    check_eq("unmapped_rdata", rdata, 0);
    pready = 0;
    bus(A_PRINT, 1, 4'hF, 32'h41);
    bus(A_PRINT, 1, 4'hF, 32'h42);
    req = 1; addr = A_TCTRL; we = 0; be = 4'hF; rst = 1;
    step();
    rst = 0; req = 0;
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_fifo", pvalid, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      req    = ($urandom_range(0, 9) < 7);
      we     = $urandom_range(0, 1);
      pready = $urandom_range(0, 1);
      be     = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      wdata  = $urandom;
      case ($urandom_range(0, 6))
        0, 6: a = A_PRINT;
        1: begin a = A_STATUS; if ($urandom_range(0, 1) == 1) wdata = MAGIC; end
        2: a = A_EXIT;
        3: begin a = A_TVAL; wdata = $urandom_range(0, 12); end
        4: a = A_TCTRL;
        default: a = $urandom;
      endcase
      addr = a | 32'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
